ysram_row_packer: RTL
=====================

# ysram_row_packer

Packs a stream of nonzero complex matrix entries, given as element and column position, into the 256-bit, four-slot YSRAM row format that the compute-side `decoder`/`selector` path consumes. It is the writer end of that format: it accepts entries from the update/load path, assembles words, marks row ends with the EOF bit, and issues held write requests on the YSRAM write port (`WE`/`WriteReq`/`WriteBus`) toward `MainArbiter_1`. One matrix per start/end-of-matrix session.

## Interface
- `BASE_ADDR`, default 0: first YSRAM word address written after `start`.
- `MAX_ADDR`, default 2047: last legal YSRAM word address (11-bit space).
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse in IDLE. Begins a session and loads the address counter with `BASE_ADDR`.
- `in_valid`  in  1  entry valid.
- `in_ready`  out  1  entry accepted on a cycle where `in_valid && in_ready`.
- `in_element`  in  48  {real[23:0], imag[23:0]}.
- `in_pos`  in  13  column position of the entry.
- `in_last`  in  1  entry is the last of its matrix row.
- `in_eom`  in  1  entry is the last of the matrix. Implies `in_last`.
- `WE`  out  1  write request, held until acknowledged.
- `WrAck`  in  1  arbiter grant; the write occurs on the cycle `WE && WrAck`.
- `WriteReq`  out  11  word address.
- `WriteBus`  out  256  packed word.
- `done`  out  1  one-cycle pulse after the final word is acknowledged.
- `overflow`  out  1  sticky. Set when a word is needed past `MAX_ADDR`.
- `word_count`  out  12  words acknowledged in the current session.

## Operation
- Slot format, 64 bits. Slot k occupies `WriteBus[64k+63:64k]`, k = 0..3.
  - [63] valid.
  - [62] EOF, meaning last entry of its matrix row.
  - [61] reserved, written 0.
  - [60:48] `in_pos`.
  - [47:0] `in_element`.
- An all-zero slot is empty. Slots fill in order 0, 1, 2, 3.
- Internal storage is an assembly register (4 slots plus a fill index 0..3) and one output holding register (`pend`, address, data).
- States:
  - IDLE: `in_ready`=0. `start` moves to PACK, clears `word_count`, `overflow` and the assembly register.
  - PACK: accepts entries. An accepted entry is written into the slot at the fill index. The word completes when the index was 3 or `in_last`=1. Remaining slots stay zero.
    - On completion, the word moves to the holding register, the fill index resets to 0, and the address counter increments.
    - Completion with `in_eom` moves to FLUSH.
  - FLUSH: `in_ready`=0. Waits until `pend`=0, then moves to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `in_ready` = (state==PACK) && (!pend || WrAck).
  - The holding register accepts a new word on the same cycle the old one is acknowledged.
- `WE` = `pend`. `WriteReq` and `WriteBus` must not change while `WE`=1 and `WrAck`=0.
- Address wrap is not allowed. If a word completes while the counter is already past `MAX_ADDR`:
  - the word is dropped (no `WE`);
  - `overflow` is set;
  - packing continues so that `in_ready` never deadlocks.
- `start` outside IDLE is ignored.
- `in_valid` with `in_last`=0 and `in_eom`=1 is treated as `in_last`=1.
- `reset` mid-session: returns to IDLE. A pending write is abandoned, `WE` drops the next cycle, and partial assembly is discarded.

## Timing
- Reset values: `in_ready`=0, `WE`=0, `WriteReq`=0, `WriteBus`=0, `done`=0, `overflow`=0, `word_count`=0, state IDLE.
- Latency: an accepted completing entry in cycle N gives `WE`=1 with that word in cycle N+1.
- Throughput: one entry per cycle while `WrAck` is continuously high, giving up to one word per cycle.
- `word_count` increments in the cycle after each `WE && WrAck`.
- `done` is asserted 2 cycles after the final acknowledge: FLUSH→DONE, then registered output.
- Simultaneous events:
  - `WrAck` together with a new completing entry: the old word retires and the new word loads with no bubble.
  - `reset` together with `start`: reset wins.

## Test plan
- Reset, then `start` with `BASE_ADDR`=0, then 4 entries (pos 1, 2, 3, 4; last only on the 4th; `WrAck` tied 1) → one write at addr 0. Slots 0..3 have valid=1, EOF=0/0/0/1, positions 1..4 in [60:48].
- Row of 2 entries, then row of 5 with `in_eom` on the final entry → 3 writes at addrs 0, 1, 2:
  - word0: slots 0–1 valid, slot 1 EOF, slots 2–3 zero;
  - word1: 4 valid, no EOF;
  - word2: slot 0 valid+EOF.
  - `done` pulses once afterward; `word_count`=3.
- Hold `WrAck`=0 for 10 cycles with `pend`=1 → `WE`/`WriteReq`/`WriteBus` stable, `in_ready`=0. Release → write occurs and `in_ready`=1 in the same cycle.
- `BASE_ADDR`=2046, `MAX_ADDR`=2047, 3 single-entry rows → writes to 2046 and 2047, third word dropped, `overflow`=1, `done` still pulses.
- `reset` asserted while `WE`=1 and `WrAck`=0 → the next cycle has all outputs at reset values. A new `start` then writes from `BASE_ADDR` with a clean assembly (no stale slots).

Source files
------------

// File: rtl/ysram_row_packer.sv
// Packs column-tagged complex entries into 4-slot, 256-bit YSRAM row words and issues held write requests.
// Latency: an accepted word-completing entry shows up on WE/WriteReq/WriteBus the next cycle.
// Backpressure: one-word holding register; in_ready drops while a write is pending and not granted this cycle.
module ysram_row_packer #(
    parameter int BASE_ADDR = 0,
    parameter int MAX_ADDR  = 2047
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [47:0]  in_element,
    input  logic [12:0]  in_pos,
    input  logic         in_last,
    input  logic         in_eom,
    output logic         WE,
    input  logic         WrAck,
    output logic [10:0]  WriteReq,
    output logic [255:0] WriteBus,
    output logic         done,
    output logic         overflow,
    output logic [11:0]  word_count
);

    typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

    typedef struct packed {
        logic        valid;
        logic        eof;
        logic        rsvd;
        logic [12:0] pos;
        logic [47:0] element;
    } slot_t;

    localparam logic [11:0] baseAddr = 12'(BASE_ADDR);
    localparam logic [11:0] maxAddr  = 12'(MAX_ADDR);

    state_t            state;
    state_t            nextState;
    slot_t [3:0]       slots;
    slot_t [3:0]       mergedSlots;
    slot_t             newSlot;
    logic [1:0]        fillIdx;
    logic [11:0]       addrCnt;
    logic              pend;
    logic [10:0]       wrAddr;
    logic [255:0]      wrData;
    logic              doneReg;
    logic              ovfReg;
    logic [11:0]       wordCnt;
    logic              entryLast;
    logic              accept;
    logic              wordDone;
    logic              addrPast;
    logic              ack;

    assign in_ready   = (state == PACK) && (!pend || WrAck);
    assign accept     = in_valid && in_ready;
    assign entryLast  = in_last || in_eom;
    assign wordDone   = accept && ((fillIdx == 2'd3) || entryLast);
    // Counter is one wider than the address so "past the end" is representable.
    assign addrPast   = addrCnt > maxAddr;
    assign ack        = pend && WrAck;

    assign WE         = pend;
    assign WriteReq   = wrAddr;
    assign WriteBus   = wrData;
    assign done       = doneReg;
    assign overflow   = ovfReg;
    assign word_count = wordCnt;

    always_comb begin
        newSlot         = '0;
        newSlot.valid   = 1'b1;
        newSlot.eof     = entryLast;
        newSlot.rsvd    = 1'b0;
        newSlot.pos     = in_pos;
        newSlot.element = in_element;
        mergedSlots          = slots;
        mergedSlots[fillIdx] = newSlot;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = PACK;
            PACK:    if (wordDone && in_eom) nextState = FLUSH;
            FLUSH:   if (!pend) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slots   <= '0;
            fillIdx <= 2'd0;
            addrCnt <= 12'd0;
            pend    <= 1'b0;
            wrAddr  <= 11'd0;
            wrData  <= '0;
            doneReg <= 1'b0;
            ovfReg  <= 1'b0;
            wordCnt <= 12'd0;
        end else begin
            doneReg <= (nextState == DONE);

            if (state == IDLE && start) begin
                slots   <= '0;
                fillIdx <= 2'd0;
                addrCnt <= baseAddr;
                wordCnt <= 12'd0;
                ovfReg  <= 1'b0;
            end

            if (ack) begin
                pend    <= 1'b0;
                wordCnt <= wordCnt + 12'd1;
            end

            // A completing entry may reload the holding register in the same cycle the old word retires.
            if (wordDone) begin
                slots   <= '0;
                fillIdx <= 2'd0;
                if (addrPast) begin
                    ovfReg <= 1'b1;
                end else begin
                    pend    <= 1'b1;
                    wrAddr  <= addrCnt[10:0];
                    wrData  <= mergedSlots;
                    addrCnt <= addrCnt + 12'd1;
                end
            end else if (accept) begin
                slots   <= mergedSlots;
                fillIdx <= fillIdx + 2'd1;
            end
        end
    end

endmodule
